// File: rtl/pipe_flush_pkg.sv
// Shared definitions for the front-end flush controller: FSM encoding and
// the per-event stage masks (sized for the widest legal pipeline, sliced by users).
package pipe_flush_pkg;

    localparam int MAX_NSTAGE = 8;

    typedef logic [MAX_NSTAGE-1:0] stage_mask_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } flush_state_e;

    // A jump only needs to kill the instruction fetched behind it.
    function automatic stage_mask_t jump_mask();
        return 8'h01;
    endfunction

    // Branch/JR resolve in ID, so both IF and ID are squashed.
    function automatic stage_mask_t branch_mask();
        return 8'h03;
    endfunction

    function automatic stage_mask_t all_ones(input int unsigned n);
        stage_mask_t m;
        m = 8'hFF >> (MAX_NSTAGE - n);
        return m;
    endfunction

endpackage

// File: rtl/pipe_flush_ctrl_if.sv
// Event, control-bundle and status signals between the pipeline and the flush controller.
interface pipe_flush_ctrl_if #(
    parameter int NSTAGE = 2,
    parameter int CTRLW  = 10,
    parameter int CNTW   = 16
);
    logic              stall;
    logic              jump;
    logic              bne;
    logic              jr;
    logic              exc;
    logic              cnt_clr;
    logic [CTRLW-1:0]  ctrl_in;
    logic [CTRLW-1:0]  ctrl_out;
    logic [NSTAGE-1:0] stage_flush;
    logic              busy;
    logic [CNTW-1:0]   flush_count;

    modport master (
        output stall, jump, bne, jr, exc, cnt_clr, ctrl_in,
        input  ctrl_out, stage_flush, busy, flush_count
    );

    modport slave (
        input  stall, jump, bne, jr, exc, cnt_clr, ctrl_in,
        output ctrl_out, stage_flush, busy, flush_count
    );
endinterface

// File: rtl/pipe_flush_ctrl_sat_counter.sv
// Saturating up-counter with a clear that takes priority over the increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Count register: clear wins, then increment until all-ones is reached.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= {W{1'b0}};
        end else if (clr) begin
            q <= {W{1'b0}};
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/pipe_flush_ctrl.sv
// Front-end squash controller: turns jump/branch/exception events into per-stage
// flush strobes, deferring them across stalls and stretching exceptions over EXC_CYC cycles.
module pipe_flush_ctrl
    import pipe_flush_pkg::*;
#(
    parameter int NSTAGE  = 2,
    parameter int CTRLW   = 10,
    parameter int EXC_CYC = 2,
    parameter int CNTW    = 16
) (
    input  logic             clk,
    input  logic             reset,
    pipe_flush_ctrl_if.slave bus
);

    localparam stage_mask_t JM_FULL  = jump_mask();
    localparam stage_mask_t BM_FULL  = branch_mask();
    localparam stage_mask_t ALL_FULL = all_ones(NSTAGE);
    localparam logic [NSTAGE-1:0] JMASK   = JM_FULL[NSTAGE-1:0];
    localparam logic [NSTAGE-1:0] BMASK   = BM_FULL[NSTAGE-1:0];
    localparam logic [NSTAGE-1:0] ALLMASK = ALL_FULL[NSTAGE-1:0];
    localparam logic [3:0]        DRAIN_LOAD = 4'(EXC_CYC - 1);
    localparam bit                USE_DRAIN  = (EXC_CYC > 1);

    flush_state_e      state_r;
    logic [NSTAGE-1:0] pend_mask_r;
    logic              pend_exc_r;
    logic [3:0]        drain_cnt_r;

    logic [NSTAGE-1:0] event_mask_s;
    logic [NSTAGE-1:0] active_mask_s;
    logic [NSTAGE-1:0] stage_flush_s;
    logic [CTRLW-1:0]  ctrl_out_s;
    logic [CNTW-1:0]   count_s;

    // Event decode and flush strobe; zero-latency so the squash lands on the same edge.
    always_comb begin
        event_mask_s  = {NSTAGE{1'b0}};
        active_mask_s = {NSTAGE{1'b0}};
        stage_flush_s = {NSTAGE{1'b0}};
        ctrl_out_s    = bus.ctrl_in;
        if (bus.jump) begin
            event_mask_s = event_mask_s | JMASK;
        end else begin
            event_mask_s = event_mask_s;
        end
        if (bus.bne || bus.jr) begin
            event_mask_s = event_mask_s | BMASK;
        end else begin
            event_mask_s = event_mask_s;
        end
        if (bus.exc) begin
            event_mask_s = ALLMASK;
        end else begin
            event_mask_s = event_mask_s;
        end
        case (state_r)
            ST_IDLE:  active_mask_s = {NSTAGE{1'b0}};
            ST_HOLD:  active_mask_s = pend_mask_r;
            ST_DRAIN: active_mask_s = ALLMASK;
            default:  active_mask_s = {NSTAGE{1'b0}};
        endcase
        if (reset || bus.stall) begin
            stage_flush_s = {NSTAGE{1'b0}};
        end else begin
            stage_flush_s = event_mask_s | active_mask_s;
        end
        if (reset || stage_flush_s[1]) begin
            ctrl_out_s = {CTRLW{1'b0}};
        end else begin
            ctrl_out_s = bus.ctrl_in;
        end
    end

    // Flush sequencer: park masked events in HOLD across stalls, count exception drain cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            pend_mask_r <= {NSTAGE{1'b0}};
            pend_exc_r  <= 1'b0;
            drain_cnt_r <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.stall && (event_mask_s != {NSTAGE{1'b0}})) begin
                        state_r     <= ST_HOLD;
                        pend_mask_r <= event_mask_s;
                        pend_exc_r  <= bus.exc;
                    end else if (!bus.stall && bus.exc && USE_DRAIN) begin
                        state_r     <= ST_DRAIN;
                        drain_cnt_r <= DRAIN_LOAD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (bus.stall) begin
                        pend_mask_r <= pend_mask_r | event_mask_s;
                        pend_exc_r  <= pend_exc_r | bus.exc;
                    end else begin
                        pend_mask_r <= {NSTAGE{1'b0}};
                        pend_exc_r  <= 1'b0;
                        if ((pend_exc_r || bus.exc) && USE_DRAIN) begin
                            state_r     <= ST_DRAIN;
                            drain_cnt_r <= DRAIN_LOAD;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (bus.stall) begin
                        drain_cnt_r <= drain_cnt_r;
                    end else if (bus.exc) begin
                        drain_cnt_r <= DRAIN_LOAD;
                    end else if (drain_cnt_r <= 4'd1) begin
                        drain_cnt_r <= 4'd0;
                        state_r     <= ST_IDLE;
                    end else begin
                        drain_cnt_r <= drain_cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    pend_mask_r <= {NSTAGE{1'b0}};
                    pend_exc_r  <= 1'b0;
                    drain_cnt_r <= 4'd0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNTW)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.cnt_clr),
        .inc   (stage_flush_s != {NSTAGE{1'b0}}),
        .q     (count_s)
    );

    assign bus.stage_flush = stage_flush_s;
    assign bus.ctrl_out    = ctrl_out_s;
    assign bus.busy        = (state_r != ST_IDLE);
    assign bus.flush_count = count_s;

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// Directed bench for pipe_flush_ctrl (NSTAGE=4, EXC_CYC=3, CNTW=4) with a queue scoreboard
// checked by an independent negedge monitor.
module tb_pipe_flush_ctrl;

    localparam int NS = 4;
    localparam int CW = 10;
    localparam int NW = 4;

    typedef struct {
        logic [NS-1:0] sf;
        logic [CW-1:0] co;
        logic          busy;
        logic [NW-1:0] cnt;
        string         nm;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    int   checks;
    int   errors;

    pipe_flush_ctrl_if #(.NSTAGE(NS), .CTRLW(CW), .CNTW(NW)) bus ();

    pipe_flush_ctrl #(.NSTAGE(NS), .CTRLW(CW), .EXC_CYC(3), .CNTW(NW)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: drive inputs just after the edge and queue the expected mid-cycle outputs.
    task automatic cyc(input logic r, input logic stl, input logic j, input logic b,
                       input logic jr, input logic e, input logic clr, input logic [CW-1:0] ci,
                       input logic [NS-1:0] esf, input logic [CW-1:0] eco, input logic ebusy,
                       input logic [NW-1:0] ecnt, input string nm, input bit chk);
        exp_t x;
        @(posedge clk);
        #1;
        rst         = r;
        bus.stall   = stl;
        bus.jump    = j;
        bus.bne     = b;
        bus.jr      = jr;
        bus.exc     = e;
        bus.cnt_clr = clr;
        bus.ctrl_in = ci;
        if (chk) begin
            x.sf = esf; x.co = eco; x.busy = ebusy; x.cnt = ecnt; x.nm = nm;
            sb.push_back(x);
        end
    endtask

    // Monitor: compare every queued expectation against the DUT mid-cycle.
    always @(negedge clk) begin
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            checks++;
            if (bus.stage_flush !== x.sf) begin
                errors++;
                $display("FAIL %s stage_flush got %b exp %b", x.nm, bus.stage_flush, x.sf);
            end
            checks++;
            if (bus.ctrl_out !== x.co) begin
                errors++;
                $display("FAIL %s ctrl_out got %h exp %h", x.nm, bus.ctrl_out, x.co);
            end
            checks++;
            if (bus.busy !== x.busy) begin
                errors++;
                $display("FAIL %s busy got %b exp %b", x.nm, bus.busy, x.busy);
            end
            checks++;
            if (bus.flush_count !== x.cnt) begin
                errors++;
                $display("FAIL %s flush_count got %0d exp %0d", x.nm, bus.flush_count, x.cnt);
            end
        end
    end

    localparam logic [CW-1:0] C0 = 10'h2A5;
    localparam logic [CW-1:0] C1 = 10'h155;
    localparam logic [CW-1:0] C2 = 10'h3FF;

    initial begin
        int wait_cyc;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.stall = 1'b0; bus.jump = 1'b0; bus.bne = 1'b0; bus.jr = 1'b0;
        bus.exc = 1'b0; bus.cnt_clr = 1'b0; bus.ctrl_in = 10'h000;

        //   r     stl   j     b     jr    e     clr   ci   sf       co       busy  cnt
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C0, 4'b0000, 10'h000, 1'b0, 4'd0, "rst0", 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, C0, 4'b0000, 10'h000, 1'b0, 4'd0, "rst_force", 1'b1);
        // jump, unstalled: zero-latency IF squash, ID bundle passes
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C1, 4'b0001, C1,      1'b0, 4'd0, "jump", 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C1, 4'b0000, C1,      1'b0, 4'd1, "jump_idle", 1'b1);
        // bne held under a 3-cycle stall, released on the 4th
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C1, 4'b0000, C1,      1'b0, 4'd1, "bne_st1", 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C1, 4'b0000, C1,      1'b1, 4'd1, "bne_st2", 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C1, 4'b0000, C1,      1'b1, 4'd1, "bne_st3", 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C2, 4'b0011, 10'h000, 1'b1, 4'd1, "bne_rel", 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C2, 4'b0000, C2,      1'b0, 4'd2, "bne_idle", 1'b1);
        // jump + jr together
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C2, 4'b0011, 10'h000, 1'b0, 4'd2, "jump_jr", 1'b1);
        // jump into HOLD, exc merges in HOLD, single all-ones release then drain
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C2, 4'b0000, C2,      1'b0, 4'd3, "hold_jump", 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C2, 4'b0000, C2,      1'b1, 4'd3, "hold_exc", 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C2, 4'b1111, 10'h000, 1'b1, 4'd3, "merge_rel", 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C2, 4'b1111, 10'h000, 1'b1, 4'd4, "merge_dr1", 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C2, 4'b1111, 10'h000, 1'b1, 4'd5, "merge_dr2", 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C2, 4'b0000, C2,      1'b0, 4'd6, "merge_idle", 1'b1);
        // exception with a stall in the middle of the drain
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C2, 4'b1111, 10'h000, 1'b0, 4'd6, "exc_c1", 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C2, 4'b1111, 10'h000, 1'b1, 4'd7, "exc_c2", 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C2, 4'b0000, C2,      1'b1, 4'd8, "exc_stall", 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C2, 4'b1111, 10'h000, 1'b1, 4'd8, "exc_c3", 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C2, 4'b0000, C2,      1'b0, 4'd9, "exc_idle", 1'b1);
        // clear with a simultaneous flush wins
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, C2, 4'b0001, C2,      1'b0, 4'd9, "clr_flush", 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C2, 4'b0000, C2,      1'b0, 4'd0, "clr_done", 1'b1);
        // 20 flush cycles saturate the 4-bit counter at 15
        for (int k = 0; k < 20; k++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C2, 4'b0001, C2, 1'b0,
                (k < 15) ? 4'(k) : 4'd15, "sat_run", 1'b1);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C2, 4'b0000, C2,      1'b0, 4'd15, "sat_hold", 1'b1);
        // reset in the middle of a drain
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C2, 4'b1111, 10'h000, 1'b0, 4'd15, "rd_exc", 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C2, 4'b0000, 10'h000, 1'b1, 4'd15, "rd_rst", 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C2, 4'b0000, C2,      1'b0, 4'd0, "rd_after", 1'b1);
        // reset while an event is parked in HOLD discards it
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C2, 4'b0000, C2,      1'b0, 4'd0, "rh_hold", 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C2, 4'b0000, 10'h000, 1'b1, 4'd0, "rh_rst", 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C2, 4'b0000, C2,      1'b0, 4'd0, "rh_after", 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C2, 4'b0000, C2,      1'b0, 4'd0, "rh_quiet", 1'b1);

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain scoreboard left %0d exp 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
